key_turn_conditioner: RTL and testbench
=======================================

// Module: key_turn_conditioner
// PURPOSE
//  Input stage between raw DE-board push-buttons KEY1/KEY3 and snake_game_fsm. Synchronises, debounces
//  and edge-detects each key, then holds at most one pending turn request per game step.
//  The request is presented on right_P/left_P until the next game_tik consumes it.
//  Replaces the raw ~KEY1/~KEY3 hookup in game_wrapper.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  clock_25 cycles a key must stay stable to be accepted (10 ms)
//  DEB_CNT_BIT      18      width of debounce counter; must hold DEBOUNCE_CYCLES-1
//  REPEAT_CYCLES    5000000 hold time between auto-repeat presses (0.2 s); used only with KEY_AUTO_REPEAT_EN
// PORTS
//  clock_25     in   1  25 MHz system clock, the single clock of the block
//  reset        in   1  asynchronous, active-low reset (KEY0)
//  key_right_n  in   1  raw KEY1, active-low, asynchronous to clock_25
//  key_left_n   in   1  raw KEY3, active-low, asynchronous to clock_25
//  game_tik     in   1  one-cycle game step strobe from game_delay
//  right_P      out  1  pending right-turn request, level, to snake_game_fsm
//  left_P       out  1  pending left-turn request, level, to snake_game_fsm
// BEHAVIOUR
//  - reset low: all sync flops=1 (released), debounced state=released, counters=0, FSM=IDLE.
//    right_P=0, left_P=0. Takes effect immediately and asynchronously.
//  - Sync: 2-flop synchroniser per key. Debounce:
//    - Counter clears whenever the synced value equals the stable state.
//    - Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the stable state flips and the counter clears.
//  - Press event: one-cycle pulse on a stable released->pressed flip. Release generates no event.
//  - Latency: raw edge to press event = 2 sync + DEBOUNCE_CYCLES cycles. Glitches shorter than that are discarded.
//  - FSM states: IDLE, PEND_R, PEND_L. Outputs are registered: right_P=(state==PEND_R), left_P=(state==PEND_L).
//    Never both high.
//  - Transitions, evaluated each cycle in this priority order:
//    1. game_tik=1 consumes the pending request; the base state becomes IDLE.
//    2. A press_r event alone then loads PEND_R. A press_l event alone loads PEND_L (latest press wins,
//       overwrites an opposite pending request).
//    3. press_r and press_l in the same cycle: both ignored, the base state is kept.
//  - Press coincident with game_tik: the current request is consumed by that tik. The new press becomes
//    pending for the next tik.
//  - The FSM samples right_P/left_P on the game_tik cycle. The request is therefore seen by exactly one game step.
//  - Holding a key produces one press only. Reset mid-debounce discards partial counts.
// CONFIGURATION
//  KEY_AUTO_REPEAT_EN defined:
//    - Per key, a repeat counter runs while the stable state is pressed.
//    - It emits an extra press event every REPEAT_CYCLES and clears on release or on reset.
//    - Repeat events follow the same FSM rules as presses.
//  KEY_AUTO_REPEAT_EN undefined: no repeat counters are built; one event per physical press.
// STRUCTURE
//  snake_defs.vh (shared include):
//    - FSM state localparams: IDLE=2'd0, PEND_R=2'd1, PEND_L=2'd2.
//    - Default DEBOUNCE_CYCLES and REPEAT_CYCLES.
//  Sub-module key_debouncer (instantiated twice) contains the synchroniser, debounce counter, stable
//  state, press pulse and optional repeat counter. The top of this block holds the request FSM only.
// TESTING (sim with DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32)
//  1. reset low 3 cycles with keys released:
//     right_P=left_P=0 during reset and after release; FSM is IDLE.
//  2. key_right_n low and held 20 cycles, no tik:
//     right_P rises 11 cycles after the edge and stays 1.
//     game_tik pulse -> right_P=0 the next cycle, and no re-assert while still held.
//  3. key_left_n bounce 1-0-1-0 with 3-cycle pulses, then released: no event, left_P stays 0.
//  4. right press accepted, then left press accepted before any tik -> left_P=1, right_P=0.
//     Next game_tik -> both 0.
//  5. Left press event on the same cycle as game_tik while PEND_R:
//     - next cycle left_P=1, right_P=0;
//     - left_P stays 1 until the following tik.
//  6. KEY_AUTO_REPEAT_EN, right held 100 cycles, game_tik every 16 cycles:
//     right_P re-asserts every 32 cycles after the initial press. Without the macro: only one assertion.

Source files
------------

// File: rtl/key_turn_conditioner_pkg.sv
// Shared definitions for the key turn conditioner: default timing and request FSM states.
package key_turn_conditioner_pkg;

  localparam int unsigned DefDebounceCycles = 250000;
  localparam int unsigned DefDebCntBit      = 18;
  localparam int unsigned DefRepeatCycles   = 5000000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPendR = 2'd1,
    StPendL = 2'd2
  } req_state_e;

endpackage

// File: rtl/key_turn_conditioner_debouncer.sv
// One key: 2-flop synchroniser, debounce counter, registered press pulse.
// Optional auto-repeat counter built when KEY_AUTO_REPEAT_EN is defined.
module key_turn_conditioner_debouncer
  import key_turn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned DEB_CNT_BIT     = DefDebCntBit,
  parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam logic [DEB_CNT_BIT-1:0] CntMax = DEB_CNT_BIT'(DEBOUNCE_CYCLES - 1);

  logic                   sync1_q, sync2_q;
  logic                   stable_q, stable_d;
  logic                   press_q, press_d;
  logic [DEB_CNT_BIT-1:0] cnt_q, cnt_d;

  // Counter runs only while the synced level disagrees with the accepted level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_ni;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RptW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RptW-1:0] RptMax = RptW'(REPEAT_CYCLES - 1);

  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_q, rpt_d;

  always_comb begin
    rpt_cnt_d = '0;
    rpt_d     = 1'b0;
    if (!stable_q) begin
      if (rpt_cnt_q == RptMax) begin
        rpt_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpt_cnt_q <= '0;
      rpt_q     <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_q     <= rpt_d;
    end
  end

  assign press_o = press_q | rpt_q;
`else
  if (REPEAT_CYCLES == 0) begin : g_rpt_chk
    $error("REPEAT_CYCLES must be nonzero");
  end

  assign press_o = press_q;
`endif

endmodule

// File: rtl/key_turn_conditioner.sv
// Conditions KEY1/KEY3 into a single pending turn request consumed by game_tik.
// Auto-repeat of held keys is enabled by defining KEY_AUTO_REPEAT_EN.
module key_turn_conditioner
  import key_turn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned DEB_CNT_BIT     = DefDebCntBit,
  parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles
) (
  input  logic clock_25,
  input  logic reset,
  input  logic key_right_n,
  input  logic key_left_n,
  input  logic game_tik,
  output logic right_P,
  output logic left_P
);

  logic       press_r, press_l;
  req_state_e state_q, state_d;

  key_turn_conditioner_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEB_CNT_BIT    (DEB_CNT_BIT),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_deb_right (
    .clk_i  (clock_25),
    .rst_ni (reset),
    .key_ni (key_right_n),
    .press_o(press_r)
  );

  key_turn_conditioner_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEB_CNT_BIT    (DEB_CNT_BIT),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_deb_left (
    .clk_i  (clock_25),
    .rst_ni (reset),
    .key_ni (key_left_n),
    .press_o(press_l)
  );

  // Tik consumes first; a lone press then overwrites; simultaneous presses cancel.
  always_comb begin
    state_d = state_q;
    if (game_tik) begin
      state_d = StIdle;
    end
    if (press_r && !press_l) begin
      state_d = StPendR;
    end else if (press_l && !press_r) begin
      state_d = StPendL;
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign right_P = (state_q == StPendR);
  assign left_P  = (state_q == StPendL);

endmodule

// File: tb/tb_key_turn_conditioner.sv
// Directed bench for key_turn_conditioner with short debounce/repeat timing.
module tb_key_turn_conditioner;

  logic clock_25;
  logic reset;
  logic key_right_n;
  logic key_left_n;
  logic game_tik;
  logic right_P;
  logic left_P;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic kr;
    logic kl;
    logic tik;
    logic er;
    logic el;
  } vec_t;

  vec_t tbl[$];

  key_turn_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .DEB_CNT_BIT    (18),
    .REPEAT_CYCLES  (32)
  ) dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .key_right_n(key_right_n),
    .key_left_n (key_left_n),
    .game_tik   (game_tik),
    .right_P    (right_P),
    .left_P     (left_P)
  );

  initial clock_25 = 1'b0;
  always #5 clock_25 = ~clock_25;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic kr, input logic kl, input logic tik);
    @(negedge clock_25);
    key_right_n = kr;
    key_left_n  = kl;
    game_tik    = tik;
    @(posedge clock_25);
    #1;
  endtask

  task automatic check(input string name, input logic er, input logic el);
    n_total++;
    if (right_P === er && left_P === el) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got right_P=%b left_P=%b, want right_P=%b left_P=%b",
               name, right_P, left_P, er, el);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic settle();
    repeat (15) step(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int rises;
    int first_rise;
    int second_rise;
    int both_hi;
    logic prev_r;

    // Right held 20 cycles: asserts on the 11th edge after the key edge.
    for (int i = 1; i <= 20; i++) tbl.push_back('{1'b0, 1'b1, 1'b0, (i >= 11), 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 15; i++) tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    // Left bounce with 3-cycle pulses must be filtered out.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, p[0], 1'b0, 1'b0, 1'b0});
    end
    for (int i = 0; i < 15; i++) tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    key_right_n = 1'b1;
    key_left_n  = 1'b1;
    game_tik    = 1'b0;
    reset       = 1'b0;

    repeat (3) begin
      @(posedge clock_25);
      #1;
      check("reset_hold", 1'b0, 1'b0);
    end
    @(negedge clock_25);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("after_reset", 1'b0, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].kr, tbl[i].kl, tbl[i].tik);
      check($sformatf("vec%0d", i), tbl[i].er, tbl[i].el);
    end

    // Latest press overwrites opposite pending request.
    repeat (11) step(1'b0, 1'b1, 1'b0);
    check("t4_right_pend", 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    check("t4_before_left", 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t4_left_wins", 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("t4_tik_clears", 1'b0, 1'b0);
    settle();
    check("t4_release_no_event", 1'b0, 1'b0);

    // Left press lands on the same cycle as a tik while right is pending.
    repeat (11) step(1'b0, 1'b1, 1'b0);
    check("t5_right_pend", 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    check("t5_still_right", 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("t5_press_with_tik", 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    check("t5_left_held", 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("t5_next_tik", 1'b0, 1'b0);
    settle();
    check("t5_idle", 1'b0, 1'b0);

    // Right held 100 cycles with a tik every 16 cycles.
    rises       = 0;
    first_rise  = -1;
    second_rise = -1;
    both_hi     = 0;
    prev_r      = right_P;
    for (int k = 1; k <= 120; k++) begin
      step((k > 100), 1'b1, (k % 16 == 0));
      if (right_P && left_P) both_hi++;
      if (right_P && !prev_r) begin
        rises++;
        if (first_rise < 0) first_rise = k;
        else if (second_rise < 0) second_rise = k;
      end
      prev_r = right_P;
    end
    check_int("t6_first_rise_cycle", first_rise, 11);
    check_int("t6_never_both", both_hi, 0);
`ifdef KEY_AUTO_REPEAT_EN
    check_int("t6_rise_count", rises, 4);
    check_int("t6_second_rise_cycle", second_rise, 43);
`else
    check_int("t6_rise_count", rises, 1);
    check_int("t6_no_second_rise", second_rise, -1);
`endif
    check("t6_end_idle", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
